// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the RV32I pipeline stages.
//   - opcode constants for the instruction classes the main decoder recognises
//   - ALUOp encodings passed from the decoder to ALU control
//   - ctrl_t: packed control-bit bundle carried down the pipeline
//   - CTRL_NOP: control bundle with no side effects (used for bubbles)
package pipeline_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] I_TYPE = 7'b0010011;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // LW/SW: address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RI     = 2'b10;  // R/I-type: funct fields decide

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
//   in : ex_valid, ex_memread, ex_rd   - instruction currently in EX
//   in : id_valid, id_rs1, id_rs2,
//        id_alusrc, id_memwrite        - instruction currently in ID
//   out: hz - ID reads the register the EX load has not yet produced
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REGIDX = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REGIDX-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REGIDX-1:0] id_rs1,
  input  logic [REGIDX-1:0] id_rs2,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  output logic              hz
);

  logic load_in_ex;
  logic rs2_used;

  // x0 is hardwired to zero, so a load targeting it never produces a value.
  assign load_in_ex = ex_valid & ex_memread & id_valid & (ex_rd != '0);

  // rs2 is a real source for R-type and branches (alusrc=0) and for stores,
  // which read rs2 as store data even though the ALU takes the immediate.
  assign rs2_used = ~id_alusrc | id_memwrite;

  assign hz = load_in_ex & ((ex_rd == id_rs1) | (rs2_used & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage RV32I core.
//   in : clk, reset (synchronous, active-high)
//   in : id_* - decoded control bits, operands, indices and funct fields
//   in : ex_flush - taken branch resolved in EX this cycle
//   out: ex_* - registered copies of every id_* field, ex_valid
//   out: stall - combinational; hold PC and IF/ID this cycle
//   out: stall_count, flush_count - saturating event counters
// A flush or a load-use hazard loads a bubble (everything zero) into EX.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REGIDX-1:0] id_rs1,
  input  logic [REGIDX-1:0] id_rs2,
  input  logic [REGIDX-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REGIDX-1:0] ex_rs1,
  output logic [REGIDX-1:0] ex_rs2,
  output logic [REGIDX-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              stall,
  output logic [XLEN-1:0]   stall_count,
  output logic [XLEN-1:0]   flush_count
);

  ctrl_t id_ctrl;
  logic  hz;

  ctrl_t             ctrl_d,   ctrl_q;
  logic              valid_d,  valid_q;
  logic [XLEN-1:0]   pc_d,     pc_q;
  logic [XLEN-1:0]   rd1_d,    rd1_q;
  logic [XLEN-1:0]   rd2_d,    rd2_q;
  logic [XLEN-1:0]   imm_d,    imm_q;
  logic [REGIDX-1:0] rs1_d,    rs1_q;
  logic [REGIDX-1:0] rs2_d,    rs2_q;
  logic [REGIDX-1:0] rd_d,     rd_q;
  logic [2:0]        funct3_d, funct3_q;
  logic [6:0]        funct7_d, funct7_q;
  logic [XLEN-1:0]   stall_count_d, stall_count_q;
  logic [XLEN-1:0]   flush_count_d, flush_count_q;

  assign id_ctrl = {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                    id_memwrite, id_aluop, id_branch};

  load_use_detect #(.REGIDX(REGIDX)) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_memread  (ctrl_q.memread),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_alusrc   (id_alusrc),
    .id_memwrite (id_memwrite),
    .hz          (hz)
  );

  // A flush already discards whatever ID holds, so holding it would be wasted.
  assign stall = hz & ~ex_flush;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    // The default is the bubble; only the capture path overrides it.
    ctrl_d   = CTRL_NOP;
    valid_d  = 1'b0;
    pc_d     = '0;
    rd1_d    = '0;
    rd2_d    = '0;
    imm_d    = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    rd_d     = '0;
    funct3_d = '0;
    funct7_d = '0;
    if (!ex_flush && !hz) begin
      // An empty ID slot keeps its data but must not carry side effects.
      ctrl_d   = id_valid ? id_ctrl : CTRL_NOP;
      valid_d  = id_valid;
      pc_d     = id_pc;
      rd1_d    = id_rd1;
      rd2_d    = id_rd2;
      imm_d    = id_imm;
      rs1_d    = id_rs1;
      rs2_d    = id_rs2;
      rd_d     = id_rd;
      funct3_d = id_funct3;
      funct7_d = id_funct7;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;

    flush_count_d = flush_count_q;
    if (ex_flush && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it only acts at a rising edge, so the
    // outputs keep their old values until the first edge with reset high.
    if (reset) begin
      ctrl_q        <= CTRL_NOP;
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      funct3_q      <= funct3_d;
      funct7_q      <= funct7_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_pc       = pc_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7   = funct7_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
// The driver applies one ID-stage instruction per cycle and pushes the
// hand-derived response (stall in that cycle, EX contents and counters after
// the edge). A separate monitor pops each entry and compares it to the DUT.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int XLEN   = 32;
  localparam int REGIDX = 5;
  localparam int DW     = 4 * XLEN + 10;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REGIDX-1:0] rs1;
    logic [REGIDX-1:0] rs2;
    logic [REGIDX-1:0] rd;
    logic [2:0]        f3;
    logic [6:0]        f7;
  } instr_t;

  typedef struct packed {
    logic              chk_stall;
    logic              stall;
    logic              valid;
    ctrl_t             ctrl;
    logic [3*REGIDX-1:0] idx;
    logic [DW-1:0]     data;
    logic [XLEN-1:0]   sc;
    logic [XLEN-1:0]   fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic id_alusrc = 1'b0, id_memtoreg = 1'b0, id_regwrite = 1'b0;
  logic id_memread = 1'b0, id_memwrite = 1'b0, id_branch = 1'b0;
  logic [1:0] id_aluop = '0;
  logic [XLEN-1:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [REGIDX-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_funct3 = '0;
  logic [6:0] id_funct7 = '0;
  logic ex_flush = 1'b0;

  logic ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0] ex_aluop;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [REGIDX-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic stall;
  logic [XLEN-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  id_ex_stage #(.XLEN(XLEN), .REGIDX(REGIDX)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_aluop(id_aluop),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [7:0] c,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rd1,
                                input logic [XLEN-1:0] rd2, input logic [XLEN-1:0] imm,
                                input logic [REGIDX-1:0] rs1, input logic [REGIDX-1:0] rs2,
                                input logic [REGIDX-1:0] rd, input logic [2:0] f3,
                                input logic [6:0] f7);
    instr_t i;
    i.valid = v; i.ctrl = ctrl_t'(c); i.pc = pc; i.rd1 = rd1; i.rd2 = rd2; i.imm = imm;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.f3 = f3; i.f7 = f7;
    return i;
  endfunction

  // Control byte layout: {alusrc, memtoreg, regwrite, memread, memwrite, aluop[1:0], branch}
  instr_t add3, lw5, add6, addi6, lw0, add600, sw5, inv3, rnd;

  // One cycle of stimulus. cap=1: EX should capture ins; cap=0: bubble.
  task automatic step(input instr_t ins, input logic flush, input logic rst,
                      input logic chk_stall, input logic exp_stall, input logic cap,
                      input logic [XLEN-1:0] sc, input logic [XLEN-1:0] fc);
    exp_t e;
    @(negedge clk);
    reset = rst; ex_flush = flush;
    id_valid = ins.valid;
    {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_aluop, id_branch} = ins.ctrl;
    id_pc = ins.pc; id_rd1 = ins.rd1; id_rd2 = ins.rd2; id_imm = ins.imm;
    id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
    id_funct3 = ins.f3; id_funct7 = ins.f7;
    e.chk_stall = chk_stall;
    e.stall = exp_stall;
    e.valid = cap ? ins.valid : 1'b0;
    e.ctrl  = (cap && ins.valid) ? ins.ctrl : CTRL_NOP;
    e.idx   = cap ? {ins.rs1, ins.rs2, ins.rd} : '0;
    e.data  = cap ? {ins.pc, ins.rd1, ins.rd2, ins.imm, ins.f3, ins.f7} : '0;
    e.sc = sc;
    e.fc = fc;
    sb.push_back(e);
  endtask

  // Monitor: stall is sampled mid-cycle (before the edge), EX state after it.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        s = stall;
        @(posedge clk);
        #1;
        if (e.chk_stall) check("stall", DW'(s), DW'(e.stall));
        check("ex_valid", DW'(ex_valid), DW'(e.valid));
        check("ex_ctrl", DW'({ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                              ex_memwrite, ex_aluop, ex_branch}), DW'(e.ctrl));
        check("ex_idx", DW'({ex_rs1, ex_rs2, ex_rd}), DW'(e.idx));
        check("ex_data", {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_funct3, ex_funct7}, e.data);
        check("stall_count", DW'(stall_count), DW'(e.sc));
        check("flush_count", DW'(flush_count), DW'(e.fc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete (got running, expected finished)");
    $fatal(1, "timeout");
  end

  localparam logic [XLEN-1:0] SAT_M1 = 32'hFFFF_FFFE;
  localparam logic [XLEN-1:0] SAT    = 32'hFFFF_FFFF;

  initial begin
    add3   = mk(1'b1, 8'h24, 32'h100, 32'h11,   32'h22, 32'h0, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00);
    lw5    = mk(1'b1, 8'hF0, 32'h104, 32'h1000, 32'h55, 32'h0, 5'd1, 5'd9, 5'd5, 3'b010, 7'h00);
    add6   = mk(1'b1, 8'h24, 32'h108, 32'h77,   32'h22, 32'h0, 5'd5, 5'd2, 5'd6, 3'b000, 7'h00);
    addi6  = mk(1'b1, 8'hA4, 32'h10C, 32'h70,   32'h50, 32'h5, 5'd7, 5'd5, 5'd6, 3'b000, 7'h00);
    lw0    = mk(1'b1, 8'hF0, 32'h110, 32'h1000, 32'h0,  32'h8, 5'd1, 5'd8, 5'd0, 3'b010, 7'h00);
    add600 = mk(1'b1, 8'h24, 32'h114, 32'h0,    32'h0,  32'h0, 5'd0, 5'd0, 5'd6, 3'b000, 7'h00);
    sw5    = mk(1'b1, 8'h88, 32'h118, 32'h1000, 32'h55, 32'h4, 5'd1, 5'd5, 5'd4, 3'b010, 7'h00);
    inv3   = add3;
    inv3.valid = 1'b0;

    // Reset with random ID contents: EX and counters stay zero.
    for (int i = 0; i < 3; i++) begin
      rnd = mk(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, $urandom,
               $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
      step(rnd, 1'b0, 1'b1, (i != 0), 1'b0, 1'b0, '0, '0);
    end

    //    ins     flush rst  chkS stall cap  stall_cnt flush_cnt
    step(add3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);  // pass-through
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    step(add6,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0);  // load-use: bubble
    step(add6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);  // held add captured
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);
    step(addi6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);  // rs2 ignored (alusrc)
    step(lw0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);
    step(add600, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);  // ex_rd == 0
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0);
    step(sw5,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0);  // store data rs2
    step(sw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd0);
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd0);
    step(add6,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd1);  // flush beats hazard
    step(add6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd1);
    step(add3,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2);  // plain flush
    step(inv3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd2);  // invalid: ctrl cleared
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 32'd2);
    step(add6,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);  // reset mid-stall
    step(add6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);  // no residual stall

    // Saturation: preload the stall counter one below all-ones before this edge.
    step(add3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SAT_M1, 32'd0);
    force dut.stall_count_q = SAT_M1;
    #1;
    release dut.stall_count_q;
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SAT_M1, 32'd0);
    step(add6,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, SAT,    32'd0);
    step(add6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SAT,    32'd0);
    step(lw5,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SAT,    32'd0);
    step(add6,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, SAT,    32'd0);  // holds at all-ones
    step(add6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SAT,    32'd0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
